pmem_sched: RTL and testbench

- Downstream stage between the L2/victim-cache pair and the physical-memory wishbone bus.
- Owns the pmem bus. Accepts line reads from L2 and dirty-line writebacks from the victim cache.
- Buffers writebacks in a small FIFO and issues one pmem transaction at a time.
- Reads take priority over writebacks. A read whose address hits a queued writeback is serviced from the buffer, so stale lines are never fetched from pmem.

---
 rtl/pmem_sched.sv | 138 +++++++++++++
 tb/tb_pmem_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_sched.sv
// Sole master of the pmem wishbone bus: serves L2 line reads (priority) and drains buffered victim writebacks.
// Read forwarded from a queued writeback in 1 cycle, else pmem latency + 1; full queue withholds wb_ack.
module pmem_sched #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 128,
   parameter int DEPTH  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_rd_req,
   input  logic [ADDR_W-1:0]      i_rd_adr,
   output logic                   o_rd_ack,
   output logic [DATA_W-1:0]      o_rd_data,
   input  logic                   i_wb_req,
   input  logic [ADDR_W-1:0]      i_wb_adr,
   input  logic [DATA_W-1:0]      i_wb_data,
   output logic                   o_wb_ack,
   output logic [$clog2(DEPTH):0] o_wbq_count,
   output logic                   o_busy,
   output logic                   o_pmem_cyc,
   output logic                   o_pmem_stb,
   output logic                   o_pmem_we,
   output logic [DATA_W/8-1:0]    o_pmem_sel,
   output logic [ADDR_W-1:0]      o_pmem_adr,
   output logic [DATA_W-1:0]      o_pmem_dat_m,
   input  logic [DATA_W-1:0]      i_pmem_dat_s,
   input  logic                   i_pmem_ack
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {S_IDLE, S_FWD, S_RD, S_WR, S_RESP} state_t;

   state_t            r_state;
   state_t            w_nxt;
   logic [ADDR_W-1:0] r_adr [DEPTH];
   logic [DATA_W-1:0] r_dat [DEPTH];
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [CW-1:0]     r_count;
   logic              r_wb_ack;
   logic              r_resp_rd;
   logic [DATA_W-1:0] r_rd_data;

   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_hit;
   logic [DATA_W-1:0] w_hit_dat;
   logic [PW-1:0]     w_idx;
   logic              w_fwd;
   logic              w_rd_done;
   logic              w_in_rd;
   logic              w_in_wr;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_push    = i_wb_req && !r_wb_ack && !w_full;
   assign w_in_rd   = (r_state == S_RD);
   assign w_in_wr   = (r_state == S_WR);
   assign w_pop     = w_in_wr && i_pmem_ack;
   assign w_rd_done = w_in_rd && i_pmem_ack;
   assign w_fwd     = (r_state == S_IDLE) && (w_nxt == S_FWD);

   // Scan oldest to youngest so the last match (youngest duplicate) wins.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_dat = '0;
      w_idx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_head + PW'(k);
         if ((CW'(k) < r_count) && (r_adr[w_idx] == i_rd_adr)) begin
            w_hit     = 1'b1;
            w_hit_dat = r_dat[w_idx];
         end
      end
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            // A writeback landing this cycle defers the read so the new entry can be matched.
            if (w_push)                    w_nxt = S_IDLE;
            else if (i_rd_req && w_hit)    w_nxt = S_FWD;
            else if (i_rd_req && !w_full)  w_nxt = S_RD;
            else if (r_count != '0)        w_nxt = S_WR;
         end
         S_RD, S_WR:    if (i_pmem_ack) w_nxt = S_RESP;
         S_FWD, S_RESP: w_nxt = S_IDLE;
         default:       w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_adr[r_tail] <= i_wb_adr;
         r_dat[r_tail] <= i_wb_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_wb_ack  <= 1'b0;
         r_resp_rd <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_wb_ack <= w_push;
         if (w_push) r_tail <= r_tail + PW'(1);
         if (w_pop)  r_head <= r_head + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_fwd)          r_rd_data <= w_hit_dat;
         else if (w_rd_done) r_rd_data <= i_pmem_dat_s;
         if (w_nxt == S_RESP) r_resp_rd <= w_in_rd;
      end
   end

   assign o_rd_ack     = (r_state == S_FWD) || ((r_state == S_RESP) && r_resp_rd);
   assign o_rd_data    = r_rd_data;
   assign o_wb_ack     = r_wb_ack;
   assign o_wbq_count  = r_count;
   assign o_busy       = (r_state != S_IDLE) || (r_count != '0);
   assign o_pmem_cyc   = w_in_rd || w_in_wr;
   assign o_pmem_stb   = w_in_rd || w_in_wr;
   assign o_pmem_we    = w_in_wr;
   assign o_pmem_sel   = (w_in_rd || w_in_wr) ? '1 : '0;
   assign o_pmem_adr   = w_in_rd ? i_rd_adr : (w_in_wr ? r_adr[r_head] : '0);
   assign o_pmem_dat_m = w_in_wr ? r_dat[r_head] : '0;

endmodule

// File: tb/tb_pmem_sched.sv
// Directed bench for pmem_sched: pmem slave model, expected-transaction and expected-read-data queues.
module tb_pmem_sched;
   localparam int AW = 12;
   localparam int DW = 128;
   localparam int D  = 4;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
   } txn_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          rd_req, rd_ack, wb_req, wb_ack, busy;
   logic [AW-1:0] rd_adr, wb_adr, pmem_adr;
   logic [DW-1:0] rd_data, wb_data, pmem_dat_m, pmem_dat_s;
   logic [2:0]    wbq_count;
   logic          pmem_cyc, pmem_stb, pmem_we, pmem_ack;
   logic [15:0]   pmem_sel;

   pmem_sched #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_rd_req(rd_req), .i_rd_adr(rd_adr), .o_rd_ack(rd_ack), .o_rd_data(rd_data),
      .i_wb_req(wb_req), .i_wb_adr(wb_adr), .i_wb_data(wb_data), .o_wb_ack(wb_ack),
      .o_wbq_count(wbq_count), .o_busy(busy),
      .o_pmem_cyc(pmem_cyc), .o_pmem_stb(pmem_stb), .o_pmem_we(pmem_we), .o_pmem_sel(pmem_sel),
      .o_pmem_adr(pmem_adr), .o_pmem_dat_m(pmem_dat_m), .i_pmem_dat_s(pmem_dat_s), .i_pmem_ack(pmem_ack)
   );

   int            n_vec = 0;
   int            n_err = 0;
   txn_t          exp_pm [$];
   logic [DW-1:0] exp_rd [$];
   logic          pm_en, force_ack;
   int            pm_lat;
   logic [DW-1:0] pm_rdat;
   int            stb_hi = 0;

   localparam logic [DW-1:0] DA = 128'hAAAA_0000_1111_2222_3333_4444_5555_AAAA;
   localparam logic [DW-1:0] DB = 128'hBBBB_0000_1111_2222_3333_4444_5555_BBBB;
   localparam logic [DW-1:0] DC = 128'hCCCC_0000_0000_0000_0000_0000_0000_CCCC;
   localparam logic [DW-1:0] DD = 128'hDDDD_0000_0000_0000_0000_0000_0000_DDDD;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic exp_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_pm.push_back(txn_t'{we: 1'b1, adr: a, dat: d});
   endtask

   task automatic exp_r(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_pm.push_back(txn_t'{we: 1'b0, adr: a, dat: '0});
      exp_rd.push_back(d);
   endtask

   task automatic check_txn();
      txn_t e;
      chk("pm_pending", DW'(exp_pm.size() != 0), DW'(1));
      if (exp_pm.size() != 0) begin
         e = exp_pm.pop_front();
         chk("pm_we",  DW'(pmem_we), DW'(e.we));
         chk("pm_adr", DW'(pmem_adr), DW'(e.adr));
         chk("pm_dat", pmem_dat_m, e.dat);
         chk("pm_sel", DW'(pmem_sel), DW'(16'hFFFF));
      end
   endtask

   // pmem slave: acks after pm_lat cycles of STB; when disabled it only replays force_ack.
   task automatic responder();
      int cnt = 0;
      forever begin
         @(posedge clk); #2;
         if (pmem_stb) stb_hi++;
         if (!pm_en) begin
            cnt = 0; pmem_ack = force_ack; pmem_dat_s = '0;
         end else if (pmem_ack) begin
            cnt = 0; pmem_ack = 1'b0; pmem_dat_s = '0;
         end else if (pmem_stb) begin
            cnt++;
            if (cnt >= pm_lat) begin
               pmem_ack   = 1'b1;
               pmem_dat_s = pmem_we ? '0 : pm_rdat;
               check_txn();
            end
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!pmem_stb)
            chk("idle_bus", DW'({pmem_cyc, pmem_we, pmem_sel, pmem_adr}) | pmem_dat_m, '0);
         if (rd_ack) begin
            chk("rd_pending", DW'(exp_rd.size() != 0), DW'(1));
            if (exp_rd.size() != 0) chk("rd_data", rd_data, exp_rd.pop_front());
         end
      end
   endtask

   task automatic do_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      wb_adr = a; wb_data = d; wb_req = 1'b1;
      do begin @(posedge clk); #1; n++; end while (!wb_ack && n < 60);
      chk("wb_ack_seen", DW'(wb_ack), DW'(1));
      wb_req = 1'b0;
   endtask

   task automatic do_rd(input logic [AW-1:0] a, output int lat);
      int n = 0;
      rd_adr = a; rd_req = 1'b1;
      do begin @(posedge clk); #1; n++; end while (!rd_ack && n < 60);
      chk("rd_ack_seen", DW'(rd_ack), DW'(1));
      rd_req = 1'b0;
      lat = n;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin @(posedge clk); #1; n++; end
      chk("idle_reached", DW'(busy), DW'(0));
   endtask

   initial begin
      int   lat;
      int   s0;
      logic seen;
      rst = 1'b1; rd_req = 1'b0; rd_adr = '0; wb_req = 1'b0; wb_adr = '0; wb_data = '0;
      pmem_ack = 1'b0; pmem_dat_s = '0; pm_en = 1'b0; force_ack = 1'b0; pm_lat = 1; pm_rdat = '0;
      fork
         responder();
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_ack", DW'(rd_ack), DW'(0));
      chk("rst_count",  DW'(wbq_count), DW'(0));
      chk("rst_busy",   DW'(busy), DW'(0));
      chk("rst_rdata",  rd_data, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: plain read, 3-cycle pmem latency
      pm_en = 1'b1; pm_lat = 3; pm_rdat = 128'hDEAD;
      exp_r(12'h0A4, 128'hDEAD);
      s0 = stb_hi;
      do_rd(12'h0A4, lat);
      chk("t1_lat", DW'(lat), DW'(4));
      @(posedge clk); #1;
      chk("t1_busy", DW'(busy), DW'(0));
      chk("t1_stb_cycles", DW'(stb_hi - s0), DW'(3));

      // 2: writeback then same-address read is forwarded
      pm_lat = 2;
      exp_w(12'h100, DA);
      exp_rd.push_back(DA);
      do_wb(12'h100, DA);
      do_rd(12'h100, lat);
      chk("t2_lat", DW'(lat), DW'(1));
      chk("t2_no_bus", DW'(pmem_stb), DW'(0));
      wait_idle();

      // 3: simultaneous writeback and read of the same line
      exp_w(12'h200, DB);
      exp_rd.push_back(DB);
      fork
         do_wb(12'h200, DB);
         do_rd(12'h200, lat);
      join
      chk("t3_lat", DW'(lat), DW'(2));
      wait_idle();

      // 4: full queue; 5th writeback and a missing read wait for the head to drain
      pm_en = 1'b0; pm_lat = 1; pm_rdat = 128'h9999;
      exp_w(12'h001, DW'(1)); exp_w(12'h002, DW'(2)); exp_r(12'h009, 128'h9999);
      exp_w(12'h003, DW'(3)); exp_w(12'h004, DW'(4)); exp_w(12'h005, DW'(5));
      for (int i = 1; i <= 4; i++) do_wb(AW'(i), DW'(i));
      chk("t4_count_full", DW'(wbq_count), DW'(4));
      fork
         do_wb(12'h005, DW'(5));
         do_rd(12'h009, lat);
         begin
            seen = 1'b0;
            repeat (6) begin @(posedge clk); #1; seen = seen | wb_ack; end
            chk("t4_full_noack", DW'(seen), DW'(0));
            chk("t4_full_count", DW'(wbq_count), DW'(4));
            pm_en = 1'b1;
         end
      join
      wait_idle();

      // 5: duplicate addresses, youngest forwarded, drained in order
      pm_en = 1'b0;
      exp_w(12'h300, DC); exp_w(12'h300, DD);
      exp_rd.push_back(DD);
      do_wb(12'h300, DC);
      do_wb(12'h300, DD);
      fork
         do_rd(12'h300, lat);
         begin
            repeat (3) begin @(posedge clk); #1; end
            chk("t5_count", DW'(wbq_count), DW'(2));
            pm_en = 1'b1;
         end
      join
      wait_idle();

      // 6: reset during a read, stray ack afterwards, then a clean re-issue
      pm_en = 1'b0;
      rd_adr = 12'h055; rd_req = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      chk("t6_stb_before", DW'(pmem_stb), DW'(1));
      do_wb(12'h007, DA);
      chk("t6_count_before", DW'(wbq_count), DW'(1));
      rst = 1'b1; rd_req = 1'b0;
      #1;
      chk("t6_rst_stb",   DW'(pmem_stb), DW'(0));
      chk("t6_rst_cyc",   DW'(pmem_cyc), DW'(0));
      chk("t6_rst_count", DW'(wbq_count), DW'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      force_ack = 1'b1;
      @(posedge clk); #1;
      force_ack = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("t6_stray_busy", DW'(busy), DW'(0));
      chk("t6_stray_stb",  DW'(pmem_stb), DW'(0));
      pm_en = 1'b1; pm_lat = 2; pm_rdat = 128'h5555_AAAA;
      exp_r(12'h055, 128'h5555_AAAA);
      do_rd(12'h055, lat);
      chk("t6_lat", DW'(lat), DW'(3));
      wait_idle();

      repeat (3) @(posedge clk);
      #1;
      chk("pm_left", DW'(exp_pm.size()), DW'(0));
      chk("rd_left", DW'(exp_rd.size()), DW'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
